regbank_dump_ctrl: RTL

Sequencer and read-port arbiter for the CPU register bank. It shares read port 1 between the pipeline decode stage and the debug unit. On a dump request it halts the pipeline, walks all bank registers in index order, and streams each word out over a valid/ready handshake toward the debug transmitter. When idle it is transparent: the pipeline's read-1 address passes straight through to the bank.

---
 rtl/regbank_dump_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/regbank_dump_ctrl.sv
// Register bank dump sequencer: shares bank read port 1 between the
// pipeline and a debug dump that streams every register over valid/ready.
module regbank_dump_ctrl #(
  parameter int BANK_SIZE   = 32,
  parameter int ADDR_LENGTH = 5,
  parameter int DATA_LENGTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_halted,
  output logic                   o_halt_req,
  input  logic [ADDR_LENGTH-1:0] i_pipe_reg1,
  output logic [ADDR_LENGTH-1:0] o_bank_reg1,
  input  logic [DATA_LENGTH-1:0] i_bank_rg1D,
  output logic [DATA_LENGTH-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_LENGTH-1:0] LAST_IDX =
    ADDR_LENGTH'(BANK_SIZE - 1);

  state_t                 state_q, state_d;
  logic [ADDR_LENGTH-1:0] idx_q, idx_d;
  logic [DATA_LENGTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   halt_q, halt_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [ADDR_LENGTH-1:0] bank_reg1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    halt_d    = halt_q;
    done_d    = 1'b0;
    bank_reg1 = i_pipe_reg1;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_HALT_WAIT;
          halt_d  = 1'b1;
          idx_d   = '0;
        end
      end
      S_HALT_WAIT: begin
        if (i_halted) state_d = S_READ;
      end
      S_READ: begin
        bank_reg1 = idx_q;
        data_d    = i_bank_rg1D;
        valid_d   = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: begin
        bank_reg1 = idx_q;
        // The last index ends the dump; idx never wraps.
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        halt_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        halt_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign o_bank_reg1 = bank_reg1;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_halt_req  = halt_q;
  assign o_done      = done_q;
  assign o_busy      = busy_q;

endmodule
